// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, zero-register index and action priority codes.
package hazard_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam int REG_ZERO = 0;

    // Higher code wins; only one action is applied per cycle.
    typedef enum logic [1:0] {
        ACT_NONE     = 2'd0,
        ACT_LOAD_USE = 2'd1,
        ACT_BRANCH   = 2'd2,
        ACT_MEM_WAIT = 2'd3
    } action_t;

    function automatic action_t pick_action(input logic mem_wait, input logic branch, input logic load_use);
        if (mem_wait) begin
            return ACT_MEM_WAIT;
        end else if (branch) begin
            return ACT_BRANCH;
        end else if (load_use) begin
            return ACT_LOAD_USE;
        end
        return ACT_NONE;
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter; built only with HAZARD_PERF_CNT_EN.
// Latency: count reflects events up to the previous clock edge.
// Backpressure: none, counting stops at all-ones.
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// Stall/flush/PC-enable generator for a 5-stage pipeline; HAZARD_PERF_CNT_EN adds perf counters.
// Latency: all control outputs are same-cycle combinational; state, wait counter and timeout flag are registered.
// Backpressure: a pending data-memory access freezes PC, IF_ID, ID_EX and EX_MEM and bubbles MEM_WB.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 64
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W   = 32
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_write,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
`endif
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   wait_cnt_q;
    logic [CW-1:0]   wait_cnt_d;
    logic            mem_wait;
    logic            load_use;
    logic            branch_go;
    action_t         action;

    always_comb begin
        mem_wait  = mem_req && !mem_ack;
        load_use  = ex_mem_read && (ex_rt != REG_W'(REG_ZERO)) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));
        // The cycle that ends a wait is still in MEM_WAIT; a branch held through
        // the wait is taken one cycle later, once the state is back in RUN.
        branch_go = ex_branch_taken && (state_q == ST_RUN);

        action = pick_action(mem_wait, branch_go, load_use);
        if (!reset) begin
            action = ACT_NONE;
        end

        pc_write     = 1'b1;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;

        case (action)
            ACT_MEM_WAIT: begin
                pc_write     = 1'b0;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
            end
            ACT_BRANCH: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
            ACT_LOAD_USE: begin
                pc_write    = 1'b0;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
            default: ;
        endcase

        state_d    = mem_wait ? ST_MEM_WAIT : ST_RUN;
        wait_cnt_d = '0;
        if (mem_wait) begin
            wait_cnt_d = (wait_cnt_q == CW'(TIMEOUT)) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (mem_wait && (wait_cnt_q == CW'(TIMEOUT))) begin
                mem_timeout <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt #(.W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (!pc_write),
        .count (stall_cycles)
    );

    hazard_perf_cnt #(.W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (if_id_flush),
        .count (flush_events)
    );
`endif

endmodule
